// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl
//   Collective (SCAN) controller for a single elevator car serving NUM_FLOORS floors.
//   Car buttons and hall up/down calls are latched into pending vectors. The car keeps
//   moving in its current direction while work remains ahead of it, stops at floors
//   that need service, and opens the door for DOOR_CYCLES clocks at each stop.
//
// Parameters
//   NUM_FLOORS    floors served (2..16), floor 0 = basement
//   HOME_FLOOR    floor loaded at reset
//   TRAVEL_CYCLES clocks to move one floor (>= 1)
//   DOOR_CYCLES   clocks the door dwells open per stop (>= 1)
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   car_req             in-car floor buttons (level)
//   hall_up / hall_dn   hall calls; hall_up[top] and hall_dn[0] are ignored
//   key                 penthouse access key (used only with ELEV_KEYLOCK_EN)
//   estop               emergency stop, level-sensitive
//   floor               current car floor
//   req_pend/up_pend/dn_pend  latched requests
//   moving_up/moving_dn car travelling
//   busy                high in any state except idle
//   door_open           door open
//
// Build option
//   ELEV_KEYLOCK_EN: car_req for the top floor latches only while key=1, and a pending
//   top-floor car request is dropped one cycle after key falls. Undefined: key is ignored.

module elevator_scan_ctrl #(
  parameter int unsigned NUM_FLOORS    = 5,
  parameter int unsigned HOME_FLOOR    = 1,
  parameter int unsigned TRAVEL_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES   = 3,
  localparam int unsigned FW = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] car_req,
  input  logic [NUM_FLOORS-1:0] hall_up,
  input  logic [NUM_FLOORS-1:0] hall_dn,
  input  logic                  key,
  input  logic                  estop,
  output logic [FW-1:0]         floor,
  output logic [NUM_FLOORS-1:0] req_pend,
  output logic [NUM_FLOORS-1:0] up_pend,
  output logic [NUM_FLOORS-1:0] dn_pend,
  output logic                  moving_up,
  output logic                  moving_dn,
  output logic                  busy,
  output logic                  door_open
);

  localparam int unsigned TMax = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int unsigned TW   = $clog2(TMax + 1);

  localparam logic [FW-1:0]         TopFloor = FW'(NUM_FLOORS - 1);
  localparam logic [NUM_FLOORS-1:0] FloorOne = {{(NUM_FLOORS-1){1'b0}}, 1'b1};
  localparam logic [NUM_FLOORS-1:0] TopBit   = {1'b1, {(NUM_FLOORS-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StMove, StDoor, StEstop} state_e;

  state_e                  state_q;
  logic [FW-1:0]           floor_q;
  logic                    dir_up_q;
  logic [TW-1:0]           timer_q;
  logic [NUM_FLOORS-1:0]   req_q, up_q, dn_q;
  logic                    moving_up_q, moving_dn_q, busy_q, door_open_q;

  // Any bit set strictly above / below floor f.
  function automatic logic any_above(input logic [NUM_FLOORS-1:0] v, input logic [FW-1:0] f);
    any_above = 1'b0;
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      if (i > int'(f)) any_above = any_above | v[i];
    end
  endfunction

  function automatic logic any_below(input logic [NUM_FLOORS-1:0] v, input logic [FW-1:0] f);
    any_below = 1'b0;
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      if (i < int'(f)) any_below = any_below | v[i];
    end
  endfunction

  logic [NUM_FLOORS-1:0] in_req, in_up, in_dn;
  logic [NUM_FLOORS-1:0] pend_all;
  logic [NUM_FLOORS-1:0] oh_cur, oh_nxt;
  logic [NUM_FLOORS-1:0] srv_up_cur, srv_dn_cur, srv_up_nxt, srv_dn_nxt;
  logic [NUM_FLOORS-1:0] clr_req, clr_up, clr_dn;
  logic [FW-1:0]         floor_nxt;
  logic                  at_cur, above_cur, below_cur, beyond_cur, opposite_cur;
  logic                  at_end, beyond_nxt, stop_nxt, match_cur;
  logic                  travel_done, door_done;

  // Input qualification: hall buttons that cannot exist are masked off.
  always_comb begin
    in_req = car_req;
    in_up  = hall_up & ~TopBit;
    in_dn  = hall_dn & ~FloorOne;
`ifdef ELEV_KEYLOCK_EN
    in_req[NUM_FLOORS-1] = car_req[NUM_FLOORS-1] & key;
`endif
  end

`ifndef ELEV_KEYLOCK_EN
  logic unused_key;
  assign unused_key = key;
`endif

  // Request geometry relative to the current floor and to the floor about to be reached.
  always_comb begin
    pend_all     = req_q | up_q | dn_q;
    oh_cur       = FloorOne << floor_q;
    at_cur       = pend_all[floor_q];
    above_cur    = any_above(pend_all, floor_q);
    below_cur    = any_below(pend_all, floor_q);
    beyond_cur   = dir_up_q ? above_cur : below_cur;
    opposite_cur = dir_up_q ? below_cur : above_cur;

    // Saturate at the shaft ends so the car can never run past them.
    if (dir_up_q) begin
      at_end    = (floor_q == TopFloor);
      floor_nxt = at_end ? floor_q : floor_q + FW'(1);
    end else begin
      at_end    = (floor_q == '0);
      floor_nxt = at_end ? floor_q : floor_q - FW'(1);
    end
    oh_nxt     = FloorOne << floor_nxt;
    beyond_nxt = dir_up_q ? any_above(pend_all, floor_nxt) : any_below(pend_all, floor_nxt);
    stop_nxt   = req_q[floor_nxt] | (dir_up_q ? up_q[floor_nxt] : dn_q[floor_nxt]) |
                 ~beyond_nxt | at_end;

    // A hall call in the travel direction is always served; the opposite one only when
    // nothing remains beyond, since the car is about to reverse anyway.
    srv_up_cur = (dir_up_q | ~beyond_cur) ? oh_cur : '0;
    srv_dn_cur = (~dir_up_q | ~beyond_cur) ? oh_cur : '0;
    srv_up_nxt = (dir_up_q | ~beyond_nxt) ? oh_nxt : '0;
    srv_dn_nxt = (~dir_up_q | ~beyond_nxt) ? oh_nxt : '0;
    match_cur  = |((req_q & oh_cur) | (up_q & srv_up_cur) | (dn_q & srv_dn_cur));

    travel_done = (timer_q == TW'(TRAVEL_CYCLES - 1));
    door_done   = (timer_q == TW'(DOOR_CYCLES - 1));
  end

  // Pending-bit clears; applied together with latching so a clear beats a same-cycle set.
  always_comb begin
    clr_req = '0;
    clr_up  = '0;
    clr_dn  = '0;
    unique case (state_q)
      StIdle: begin
        // Opening from idle serves everything waiting at this floor.
        if (at_cur) begin
          clr_req = oh_cur;
          clr_up  = oh_cur;
          clr_dn  = oh_cur;
        end
      end
      StMove: begin
        if (travel_done && stop_nxt) begin
          clr_req = oh_nxt;
          clr_up  = srv_up_nxt;
          clr_dn  = srv_dn_nxt;
        end
      end
      StDoor: begin
        if (match_cur) begin
          clr_req = oh_cur;
          clr_up  = srv_up_cur;
          clr_dn  = srv_dn_cur;
        end
      end
      StEstop: ;
      default: ;
    endcase
`ifdef ELEV_KEYLOCK_EN
    if (!key) clr_req = clr_req | TopBit;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      floor_q     <= FW'(HOME_FLOOR);
      dir_up_q    <= 1'b1;
      timer_q     <= '0;
      req_q       <= '0;
      up_q        <= '0;
      dn_q        <= '0;
      moving_up_q <= 1'b0;
      moving_dn_q <= 1'b0;
      busy_q      <= 1'b0;
      door_open_q <= 1'b0;
    end else if (estop) begin
      // Abort any partial travel; floor keeps the last floor actually reached.
      state_q     <= StEstop;
      timer_q     <= '0;
      req_q       <= '0;
      up_q        <= '0;
      dn_q        <= '0;
      moving_up_q <= 1'b0;
      moving_dn_q <= 1'b0;
      busy_q      <= 1'b1;
      door_open_q <= 1'b1;
    end else begin
      req_q <= (req_q | in_req) & ~clr_req;
      up_q  <= (up_q | in_up) & ~clr_up;
      dn_q  <= (dn_q | in_dn) & ~clr_dn;

      unique case (state_q)
        StIdle: begin
          timer_q <= '0;
          if (at_cur) begin
            state_q     <= StDoor;
            busy_q      <= 1'b1;
            door_open_q <= 1'b1;
          end else if (above_cur) begin
            state_q     <= StMove;
            dir_up_q    <= 1'b1;
            moving_up_q <= 1'b1;
            busy_q      <= 1'b1;
          end else if (below_cur) begin
            state_q     <= StMove;
            dir_up_q    <= 1'b0;
            moving_dn_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end

        StMove: begin
          if (travel_done) begin
            floor_q <= floor_nxt;
            timer_q <= '0;
            if (stop_nxt) begin
              state_q     <= StDoor;
              moving_up_q <= 1'b0;
              moving_dn_q <= 1'b0;
              door_open_q <= 1'b1;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end

        StDoor: begin
          if (match_cur) begin
            // Late call for this floor: serve it and hold the door for a full dwell.
            timer_q <= '0;
          end else if (door_done) begin
            timer_q     <= '0;
            door_open_q <= 1'b0;
            if (beyond_cur) begin
              state_q     <= StMove;
              moving_up_q <= dir_up_q;
              moving_dn_q <= ~dir_up_q;
            end else if (opposite_cur) begin
              state_q     <= StMove;
              dir_up_q    <= ~dir_up_q;
              moving_up_q <= ~dir_up_q;
              moving_dn_q <= dir_up_q;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end

        StEstop: begin
          state_q     <= StIdle;
          timer_q     <= '0;
          busy_q      <= 1'b0;
          door_open_q <= 1'b0;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign floor     = floor_q;
  assign req_pend  = req_q;
  assign up_pend   = up_q;
  assign dn_pend   = dn_q;
  assign moving_up = moving_up_q;
  assign moving_dn = moving_dn_q;
  assign busy      = busy_q;
  assign door_open = door_open_q;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed bench for elevator_scan_ctrl with NUM_FLOORS=5, HOME_FLOOR=1, TRAVEL_CYCLES=4,
// DOOR_CYCLES=3. Inputs are driven and outputs sampled on the falling edge; the comments
// "Nk" count falling edges after the step's starting point.

module tb_elevator_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] car_req, hall_up, hall_dn;
  logic       key, estop;
  logic [2:0] floor;
  logic [4:0] req_pend, up_pend, dn_pend;
  logic       moving_up, moving_dn, busy, door_open;

  int n_assert = 0;
  int n_fail   = 0;
  int up_cnt, door_cnt, door_floor;

  elevator_scan_ctrl #(
    .NUM_FLOORS   (5),
    .HOME_FLOOR   (1),
    .TRAVEL_CYCLES(4),
    .DOOR_CYCLES  (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .car_req  (car_req),
    .hall_up  (hall_up),
    .hall_dn  (hall_dn),
    .key      (key),
    .estop    (estop),
    .floor    (floor),
    .req_pend (req_pend),
    .up_pend  (up_pend),
    .dn_pend  (dn_pend),
    .moving_up(moving_up),
    .moving_dn(moving_dn),
    .busy     (busy),
    .door_open(door_open)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench on a falling edge with reset just released (that edge is N0).
  task automatic do_reset();
    rst_n   = 1'b0;
    car_req = '0;
    hall_up = '0;
    hall_dn = '0;
    estop   = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    key   = 1'b0;

    // Reset state
    do_reset();
    chk("rst_floor", floor, 3'd1);
    chk("rst_req", req_pend, 5'b0);
    chk("rst_up", up_pend, 5'b0);
    chk("rst_dn", dn_pend, 5'b0);
    chk("rst_door", door_open, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mov", {moving_up, moving_dn}, 2'b00);

    // Single car call 1 -> 3: 8 clocks moving up, 3 clocks door open, back to idle
    car_req = 5'b01000;
    cyc(1);                                           // N1
    car_req = '0;
    chk("t2_latch", req_pend, 5'b01000);
    chk("t2_idle_busy", busy, 1'b0);
    up_cnt = 0;
    door_cnt = 0;
    door_floor = 0;
    for (int i = 0; i < 15; i++) begin                // N2..N16
      cyc(1);
      if (moving_up) up_cnt++;
      if (door_open) begin
        door_cnt++;
        door_floor = int'(floor);
      end
    end
    chk("t2_up_cycles", up_cnt, 8);
    chk("t2_door_cycles", door_cnt, 3);
    chk("t2_door_floor", door_floor, 3);
    chk("t2_req_clr", req_pend, 5'b0);
    chk("t2_end_busy", busy, 1'b0);
    chk("t2_end_floor", floor, 3'd3);

    // 1 -> 4 with hall up at 2 latched en route: stop at 2, continue to 4
    do_reset();
    car_req = 5'b10000;
    cyc(1);                                           // N1
    car_req = '0;
    cyc(1);                                           // N2
    hall_up = 5'b00100;
    cyc(1);                                           // N3
    hall_up = '0;
    chk("t3_up_latch", up_pend, 5'b00100);
    cyc(3);                                           // N6
    chk("t3_stop2_floor", floor, 3'd2);
    chk("t3_stop2_door", door_open, 1'b1);
    chk("t3_stop2_upclr", up_pend, 5'b0);
    chk("t3_stop2_req", req_pend, 5'b10000);
    chk("t3_stop2_mov", moving_up, 1'b0);
    cyc(3);                                           // N9
    chk("t3_resume_door", door_open, 1'b0);
    chk("t3_resume_up", moving_up, 1'b1);
    cyc(4);                                           // N13
    chk("t3_pass3", floor, 3'd3);
    cyc(4);                                           // N17
    chk("t3_arr4_floor", floor, 3'd4);
    chk("t3_arr4_door", door_open, 1'b1);
    chk("t3_arr4_req", req_pend, 5'b0);
    cyc(3);                                           // N20
    chk("t3_idle", {busy, door_open}, 2'b00);

    // Going up to 4 with hall down at 2: pass 2, serve 4, reverse, stop at 2
    do_reset();
    car_req = 5'b10000;
    cyc(1);                                           // N1
    car_req = '0;
    cyc(1);                                           // N2
    hall_dn = 5'b00100;
    cyc(1);                                           // N3
    hall_dn = '0;
    cyc(3);                                           // N6
    chk("t4_pass2_floor", floor, 3'd2);
    chk("t4_pass2_door", door_open, 1'b0);
    chk("t4_pass2_up", moving_up, 1'b1);
    chk("t4_pass2_dn", dn_pend, 5'b00100);
    cyc(8);                                           // N14
    chk("t4_arr4", {floor, door_open}, {3'd4, 1'b1});
    chk("t4_arr4_dn", dn_pend, 5'b00100);
    cyc(3);                                           // N17
    chk("t4_reverse", {moving_dn, moving_up, door_open}, 3'b100);
    cyc(4);                                           // N21
    chk("t4_pass3", {floor, moving_dn}, {3'd3, 1'b1});
    cyc(4);                                           // N25
    chk("t4_arr2", {floor, door_open, moving_dn}, {3'd2, 1'b1, 1'b0});
    chk("t4_arr2_dnclr", dn_pend, 5'b0);
    cyc(3);                                           // N28
    chk("t4_idle", busy, 1'b0);

    // Emergency stop mid-travel 1 -> 3
    do_reset();
    car_req = 5'b01000;
    hall_dn = 5'b10000;
    cyc(1);                                           // N1
    car_req = '0;
    hall_dn = '0;
    cyc(6);                                           // N7
    estop = 1'b1;
    cyc(1);                                           // N8
    chk("t5_es_door", door_open, 1'b1);
    chk("t5_es_mov", {moving_up, moving_dn}, 2'b00);
    chk("t5_es_busy", busy, 1'b1);
    chk("t5_es_floor", floor, 3'd2);
    chk("t5_es_pend", {req_pend, up_pend, dn_pend}, 15'b0);
    car_req = 5'b00001;
    cyc(2);                                           // N10
    chk("t5_es_nolatch", req_pend, 5'b0);
    estop = 1'b0;
    car_req = '0;
    cyc(1);                                           // N11
    chk("t5_rel", {door_open, busy, moving_up, moving_dn}, 4'b0000);
    chk("t5_rel_floor", floor, 3'd2);
    cyc(4);                                           // N15
    chk("t5_stays", {busy, floor}, {1'b0, 3'd2});

    // Impossible hall buttons are ignored; door dwell restarts on a late call at the floor
    do_reset();
    hall_up = 5'b10000;
    hall_dn = 5'b00001;
    cyc(1);                                           // N1
    hall_up = '0;
    hall_dn = '0;
    chk("t6_mask", {up_pend, dn_pend}, 10'b0);
    cyc(2);                                           // N3 (M0)
    chk("t6_mask_idle", busy, 1'b0);
    hall_up = 5'b00010;
    cyc(1);                                           // M1
    hall_up = '0;
    chk("t6_here_latch", up_pend, 5'b00010);
    cyc(1);                                           // M2
    chk("t6_here_door", {door_open, floor}, {1'b1, 3'd1});
    chk("t6_here_clr", up_pend, 5'b0);
    car_req = 5'b00010;
    cyc(1);                                           // M3
    car_req = '0;
    chk("t6_late_latch", req_pend, 5'b00010);
    cyc(1);                                           // M4
    chk("t6_late_clr", req_pend, 5'b0);
    cyc(1);                                           // M5
    chk("t6_dwell_hold", door_open, 1'b1);
    cyc(2);                                           // M7
    chk("t6_dwell_end", {door_open, busy}, 2'b00);

    // Penthouse key handling
    do_reset();
    key = 1'b0;
    car_req = 5'b10000;
    cyc(1);                                           // N1
    car_req = '0;
`ifdef ELEV_KEYLOCK_EN
    chk("t7_nokey", req_pend, 5'b0);
    cyc(3);                                           // N4
    chk("t7_nokey_idle", {busy, floor}, {1'b0, 3'd1});
    key = 1'b1;
    car_req = 5'b10000;
    cyc(1);                                           // N5
    car_req = '0;
    chk("t7_key_latch", req_pend, 5'b10000);
    cyc(13);                                          // N18
    chk("t7_key_arr4", {floor, door_open}, {3'd4, 1'b1});
    key = 1'b0;
`else
    chk("t7_free_latch", req_pend, 5'b10000);
    cyc(1);                                           // N2
    chk("t7_free_move", {moving_up, busy}, 2'b11);
    cyc(12);                                          // N14
    chk("t7_free_arr4", {floor, door_open}, {3'd4, 1'b1});
`endif

    // Asynchronous reset mid-travel snaps the car back to home
    do_reset();
    car_req = 5'b10000;
    cyc(1);                                           // N1
    car_req = '0;
    cyc(5);                                           // N6
    chk("t8_pre", {floor, moving_up}, {3'd2, 1'b1});
    #2 rst_n = 1'b0;
    #1;
    chk("t8_async_floor", floor, 3'd1);
    chk("t8_async_state", {moving_up, busy, door_open}, 3'b000);
    chk("t8_async_pend", req_pend, 5'b0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
